// File: rtl/ni_mc_sync_if.sv
// Core-side and NoC-side signal bundle of the neuron-core network interface.
// The slave modport is the interface block itself; master is its environment.
interface ni_mc_sync_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned MSB_SLOT = 5
);
    localparam int unsigned DSIZE = 1 << MSB_SLOT;
    localparam int unsigned RSIZE = DSIZE / 2;

    logic [NUM_CH-1:0]       core_write_en;
    logic [NUM_CH*RSIZE-1:0] core_wdata;
    logic [NUM_CH*RSIZE-1:0] core_waddr;
    logic [NUM_CH-1:0]       core_wfull;
    logic                    core_read_en;
    logic [RSIZE-1:0]        core_rdata;
    logic                    core_rempty;
    logic [DSIZE-1:0]        noc_tx_data;
    logic                    noc_tx_valid;
    logic                    noc_tx_ready;
    logic [DSIZE-1:0]        noc_rx_data;
    logic                    noc_rx_valid;
    logic                    noc_rx_ready;

    modport master (
        output core_write_en, core_wdata, core_waddr, core_read_en,
        output noc_tx_ready, noc_rx_data, noc_rx_valid,
        input  core_wfull, core_rdata, core_rempty,
        input  noc_tx_data, noc_tx_valid, noc_rx_ready
    );

    modport slave (
        input  core_write_en, core_wdata, core_waddr, core_read_en,
        input  noc_tx_ready, noc_rx_data, noc_rx_valid,
        output core_wfull, core_rdata, core_rempty,
        output noc_tx_data, noc_tx_valid, noc_rx_ready
    );
endinterface

// File: rtl/ni_mc_sync.sv
// Multi-channel network interface: per-channel TX FIFOs, round-robin arbiter onto a
// registered NoC TX port, local loopback, and a first-word-fall-through RX FIFO.
module ni_mc_sync #(
    parameter int unsigned                    NUM_CH     = 2,
    parameter int unsigned                    ADDRSIZE   = 4,
    parameter int unsigned                    MSB_SLOT   = 5,
    parameter logic [(1<<MSB_SLOT)/2-1:0]     LOCAL_ADDR = '0
) (
    input logic         clk,
    input logic         rst_n,
    ni_mc_sync_if.slave bus
);
    localparam int unsigned DSIZE = 1 << MSB_SLOT;
    localparam int unsigned RSIZE = DSIZE / 2;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;
    localparam int unsigned IDXW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DSIZE-1:0]  tx_mem [NUM_CH][DEPTH];
    logic [ADDRSIZE:0] tx_wptr_q [NUM_CH];
    logic [ADDRSIZE:0] tx_rptr_q [NUM_CH];
    logic [DSIZE-1:0]  tx_head [NUM_CH];
    logic [NUM_CH-1:0] tx_empty, tx_full, tx_push, head_local, eligible;

    logic [DSIZE-1:0]  rx_mem [DEPTH];
    logic [ADDRSIZE:0] rx_wptr_q, rx_rptr_q;
    logic              rx_empty, rx_full, rx_noc_push, rx_push, rx_pop;
    logic [DSIZE-1:0]  rx_wdata;

    logic              tx_valid_q;
    logic [DSIZE-1:0]  tx_data_q;
    logic [IDXW-1:0]   rr_q;

    logic              out_load, lb_ok, gnt_valid, gnt_local;
    logic [IDXW-1:0]   gnt_idx;
    logic [DSIZE-1:0]  gnt_head;

    assign out_load    = !tx_valid_q || bus.noc_tx_ready;
    assign rx_empty    = rx_wptr_q == rx_rptr_q;
    assign rx_full     = (rx_wptr_q[ADDRSIZE] != rx_rptr_q[ADDRSIZE]) &&
                         (rx_wptr_q[ADDRSIZE-1:0] == rx_rptr_q[ADDRSIZE-1:0]);
    assign rx_noc_push = bus.noc_rx_valid && !rx_full;
    // NoC input wins the RX write port; loopback waits for a free cycle.
    assign lb_ok       = !rx_full && !rx_noc_push;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_tx
        assign tx_empty[i]   = tx_wptr_q[i] == tx_rptr_q[i];
        assign tx_full[i]    = (tx_wptr_q[i][ADDRSIZE] != tx_rptr_q[i][ADDRSIZE]) &&
                               (tx_wptr_q[i][ADDRSIZE-1:0] == tx_rptr_q[i][ADDRSIZE-1:0]);
        assign tx_push[i]    = bus.core_write_en[i] && !tx_full[i];
        assign tx_head[i]    = tx_mem[i][tx_rptr_q[i][ADDRSIZE-1:0]];
        assign head_local[i] = tx_head[i][DSIZE-1:RSIZE] == LOCAL_ADDR;
        assign eligible[i]   = !tx_empty[i] && (head_local[i] ? lb_ok : out_load);
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int unsigned c;
            c = (int'(rr_q) + k) % NUM_CH;
            if (!gnt_valid && eligible[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDXW'(c);
            end
        end
    end

    assign gnt_head  = tx_head[gnt_idx];
    assign gnt_local = head_local[gnt_idx];

    assign rx_push  = rx_noc_push || (gnt_valid && gnt_local);
    assign rx_wdata = rx_noc_push ? bus.noc_rx_data : gnt_head;
    assign rx_pop   = bus.core_read_en && !rx_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tx_wptr_q[i] <= '0;
                tx_rptr_q[i] <= '0;
            end
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rr_q       <= IDXW'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tx_push[i]) tx_wptr_q[i] <= tx_wptr_q[i] + 1'b1;
                if (gnt_valid && gnt_idx == IDXW'(i)) tx_rptr_q[i] <= tx_rptr_q[i] + 1'b1;
            end
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            if (gnt_valid) rr_q <= gnt_idx;
            // Output stage only changes when it is empty or being accepted.
            if (gnt_valid && !gnt_local) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= gnt_head;
            end else if (out_load) begin
                tx_valid_q <= 1'b0;
                tx_data_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (tx_push[i]) begin
                tx_mem[i][tx_wptr_q[i][ADDRSIZE-1:0]] <=
                    {bus.core_waddr[i*RSIZE +: RSIZE], bus.core_wdata[i*RSIZE +: RSIZE]};
            end
        end
        if (rx_push) rx_mem[rx_wptr_q[ADDRSIZE-1:0]] <= rx_wdata;
    end

    assign bus.core_wfull   = tx_full;
    assign bus.core_rempty  = rx_empty;
    assign bus.core_rdata   = rx_empty ? '0 : rx_mem[rx_rptr_q[ADDRSIZE-1:0]][RSIZE-1:0];
    assign bus.noc_tx_valid = tx_valid_q;
    assign bus.noc_tx_data  = tx_data_q;
    assign bus.noc_rx_ready = !rx_full;
endmodule

// File: tb/tb_ni_mc_sync.sv
// Directed and randomized bench for ni_mc_sync against a queue-based packet model.
module tb_ni_mc_sync;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned MSB_SLOT = 5;
    localparam int unsigned DEPTH    = 16;
    localparam logic [15:0] LOCAL    = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ni_mc_sync_if #(.NUM_CH(NUM_CH), .MSB_SLOT(MSB_SLOT)) bus ();

    ni_mc_sync #(
        .NUM_CH    (NUM_CH),
        .ADDRSIZE  (ADDRSIZE),
        .MSB_SLOT  (MSB_SLOT),
        .LOCAL_ADDR(LOCAL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_txq [NUM_CH][$];
    logic [31:0] m_rxq [$];
    logic        m_tx_valid = 1'b0;
    logic [31:0] m_tx_data  = '0;
    int          m_rr       = NUM_CH - 1;

    logic [31:0] seen_tx [$];
    logic [15:0] seen_rd [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the packet-level behaviour, using the inputs as driven now.
    function automatic void model_step();
        bit          load, rxfull, nocpush, lbok, gnt;
        int          gc;
        logic [31:0] head;
        bit          full_pre [NUM_CH];
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) m_txq[c].delete();
            m_rxq.delete();
            m_tx_valid = 1'b0;
            m_tx_data  = '0;
            m_rr       = NUM_CH - 1;
            return;
        end
        load    = !m_tx_valid || bus.noc_tx_ready;
        rxfull  = m_rxq.size() == DEPTH;
        nocpush = bus.noc_rx_valid && !rxfull;
        lbok    = !rxfull && !nocpush;
        gnt  = 1'b0;
        gc   = 0;
        head = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_rr + k) % NUM_CH;
            if (!gnt && m_txq[c].size() > 0) begin
                if ((m_txq[c][0][31:16] == LOCAL) ? lbok : load) begin
                    gnt  = 1'b1;
                    gc   = c;
                    head = m_txq[c][0];
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) full_pre[c] = m_txq[c].size() == DEPTH;
        if (bus.core_read_en && m_rxq.size() > 0) void'(m_rxq.pop_front());
        if (nocpush) m_rxq.push_back(bus.noc_rx_data);
        else if (gnt && head[31:16] == LOCAL) m_rxq.push_back(head);
        if (gnt) begin
            void'(m_txq[gc].pop_front());
            m_rr = gc;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.core_write_en[c] && !full_pre[c])
                m_txq[c].push_back({bus.core_waddr[c*16 +: 16], bus.core_wdata[c*16 +: 16]});
        end
        if (gnt && head[31:16] != LOCAL) begin
            m_tx_valid = 1'b1;
            m_tx_data  = head;
        end else if (load) begin
            m_tx_valid = 1'b0;
            m_tx_data  = '0;
        end
    endfunction

    task automatic compare();
        for (int c = 0; c < NUM_CH; c++)
            check("core_wfull", 64'(bus.core_wfull[c]), 64'(m_txq[c].size() == DEPTH));
        check("core_rempty", 64'(bus.core_rempty), 64'(m_rxq.size() == 0));
        check("core_rdata", 64'(bus.core_rdata), (m_rxq.size() > 0) ? 64'(m_rxq[0][15:0]) : 64'd0);
        check("noc_tx_valid", 64'(bus.noc_tx_valid), 64'(m_tx_valid));
        check("noc_tx_data", 64'(bus.noc_tx_data), 64'(m_tx_data));
        check("noc_rx_ready", 64'(bus.noc_rx_ready), 64'(m_rxq.size() < DEPTH));
    endtask

    task automatic cycle();
        if (rst_n && bus.noc_tx_valid && bus.noc_tx_ready) seen_tx.push_back(bus.noc_tx_data);
        if (rst_n && bus.core_read_en && !bus.core_rempty) seen_rd.push_back(bus.core_rdata);
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_idle();
        bus.core_write_en = '0;
        bus.core_wdata    = '0;
        bus.core_waddr    = '0;
        bus.core_read_en  = 1'b0;
        bus.noc_tx_ready  = 1'b1;
        bus.noc_rx_data   = '0;
        bus.noc_rx_valid  = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        seen_tx.delete();
        seen_rd.delete();
    endtask

    task automatic write(input int ch, input logic [15:0] addr, input logic [15:0] data);
        bus.core_write_en[ch]        = 1'b1;
        bus.core_waddr[ch*16 +: 16] = addr;
        bus.core_wdata[ch*16 +: 16] = data;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_wfull", 64'(bus.core_wfull), 64'd0);
        check("rst_rempty", 64'(bus.core_rempty), 64'd1);
        check("rst_tx_valid", 64'(bus.noc_tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.noc_tx_data), 64'd0);
        check("rst_rx_ready", 64'(bus.noc_rx_ready), 64'd1);

        // Single packet: valid two edges after the write, for one cycle only
        write(0, 16'h0003, 16'hABCD);
        cycle();
        set_idle();
        check("t1_valid_n", 64'(bus.noc_tx_valid), 64'd0);
        cycle();
        check("t1_valid_n1", 64'(bus.noc_tx_valid), 64'd1);
        check("t1_data", 64'(bus.noc_tx_data), 64'h0003ABCD);
        cycle();
        check("t1_valid_n2", 64'(bus.noc_tx_valid), 64'd0);

        // Round-robin interleave of two busy channels
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write(0, 16'h0001, 16'(i));
            write(1, 16'h0002, 16'(10 + i));
            cycle();
        end
        set_idle();
        repeat (10) cycle();
        check("t2_count", 64'(seen_tx.size()), 64'd8);
        for (int i = 0; i < 8 && i < seen_tx.size(); i++) begin
            logic [31:0] exp;
            exp = (i % 2 == 0) ? {16'h0001, 16'(i / 2)} : {16'h0002, 16'(10 + i / 2)};
            check("t2_order", 64'(seen_tx[i]), 64'(exp));
        end

        // Backpressure holds the output stage stable
        do_reset();
        bus.noc_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write(0, 16'h0005, 16'(16'h0100 + i));
            cycle();
        end
        bus.core_write_en = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_data", 64'(bus.noc_tx_data), 64'h00050100);
        end
        bus.noc_tx_ready = 1'b1;
        repeat (6) cycle();
        check("t3_count", 64'(seen_tx.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen_tx.size(); i++)
            check("t3_order", 64'(seen_tx[i]), 64'(32'h00050100 + i));

        // Fill channel 0 behind a stalled output stage; the overflow write is dropped
        do_reset();
        bus.noc_tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            write(0, 16'h0007, 16'(16'h0200 + i));
            cycle();
            if (i == 16) check("t4_full", 64'(bus.core_wfull[0]), 64'd1);
        end
        set_idle();
        repeat (25) cycle();
        check("t4_count", 64'(seen_tx.size()), 64'd17);
        for (int i = 0; i < 17 && i < seen_tx.size(); i++)
            check("t4_order", 64'(seen_tx[i]), 64'(32'h00070200 + i));

        // NoC input takes precedence over loopback into the RX FIFO
        do_reset();
        write(0, LOCAL, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            bus.noc_rx_valid = 1'b1;
            bus.noc_rx_data  = {16'hAAAA, 16'(i + 1)};
            cycle();
            bus.core_write_en = '0;
        end
        set_idle();
        repeat (2) cycle();
        bus.core_read_en = 1'b1;
        repeat (5) cycle();
        set_idle();
        check("t5_rd_count", 64'(seen_rd.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen_rd.size(); i++)
            check("t5_rd_order", 64'(seen_rd[i]), (i < 3) ? 64'(i + 1) : 64'h55);
        check("t5_no_tx", 64'(seen_tx.size()), 64'd0);

        // Full RX stalls loopback; one read reopens it; reset mid-transfer
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.noc_rx_valid = 1'b1;
            bus.noc_rx_data  = 32'h10000000 + i;
            cycle();
        end
        set_idle();
        check("t6_rx_full", 64'(bus.noc_rx_ready), 64'd0);
        write(0, LOCAL, 16'h0077);
        cycle();
        set_idle();
        repeat (3) cycle();
        check("t6_still_full", 64'(bus.noc_rx_ready), 64'd0);
        check("t6_head", 64'(bus.core_rdata), 64'd0);
        bus.core_read_en = 1'b1;
        cycle();
        bus.core_read_en = 1'b0;
        check("t6_reopen", 64'(bus.noc_rx_ready), 64'd1);
        cycle();
        bus.noc_tx_ready = 1'b0;
        write(1, 16'h0009, 16'h0099);
        cycle();
        set_idle();
        bus.noc_tx_ready = 1'b0;
        cycle();
        check("t6_tx_pending", 64'(bus.noc_tx_valid), 64'd1);
        rst_n = 1'b0;
        cycle();
        check("t6_rst_rempty", 64'(bus.core_rempty), 64'd1);
        check("t6_rst_tx_valid", 64'(bus.noc_tx_valid), 64'd0);
        rst_n = 1'b1;

        // Randomized traffic with occasional resets
        set_idle();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus.core_write_en[c]        = $urandom_range(0, 2) == 0;
                bus.core_waddr[c*16 +: 16] = ($urandom_range(0, 3) == 0) ? LOCAL
                                                                           : 16'($urandom);
                bus.core_wdata[c*16 +: 16] = 16'($urandom);
            end
            bus.noc_tx_ready = $urandom_range(0, 3) != 0;
            bus.noc_rx_valid = $urandom_range(0, 2) == 0;
            bus.noc_rx_data  = $urandom;
            bus.core_read_en = $urandom_range(0, 2) != 0;
            rst_n            = $urandom_range(0, 149) != 0;
            cycle();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
